// File: rtl/serial_word_collector.sv
// serial_word_collector
// Packs WIDTH serial bits (one per accepted cycle) into a parallel word and
// offers it downstream, stalling the serial source while a word is held.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. A source keeps its data stable while
// valid is high and ready is low. bit_ready depends only on the FSM state and
// never on bit_valid; word_valid/word_out depend only on registered state and
// never on word_ready.
module serial_word_collector #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic                       bit_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;

  // Shift register value after taking in bit_in, in the configured bit order.
  always_comb begin
    shifted = shreg_q;
    if (MSB_FIRST) begin
      shifted = {shreg_q[WIDTH-2:0], bit_in};
    end else begin
      shifted = {bit_in, shreg_q[WIDTH-1:1]};
    end
  end

  assign last_bit = (count_q == CW'(WIDTH-1));

  // Next-state logic: collect bits, complete a word, hold it until taken.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    count_d = count_q;
    valid_d = valid_q;
    unique case (state_q)
      COLLECT: begin
        // Flush wins over a bit presented in the same cycle.
        if (flush) begin
          shreg_d = '0;
          count_d = '0;
        end else if (bit_valid) begin
          shreg_d = shifted;
          if (last_bit) begin
            word_d  = shifted;
            valid_d = 1'b1;
            count_d = '0;
            state_d = HOLD;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      HOLD: begin
        // Serial input and flush are ignored; only the word handshake moves on.
        if (word_ready) begin
          valid_d = 1'b0;
          shreg_d = '0;
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      shreg_q <= '0;
      word_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign bit_ready  = (state_q == COLLECT);
  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign bit_count  = count_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Bench for serial_word_collector: an MSB-first and an LSB-first instance
// share the same stimulus and are compared against a queue-based model of
// the collected bits and the held word.
module tb_serial_word_collector;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          flush = 1'b0;
  logic          word_ready = 1'b0;
  logic          m_bit_ready, l_bit_ready;
  logic [W-1:0]  m_word_out, l_word_out;
  logic          m_word_valid, l_word_valid;
  logic [CW-1:0] m_bit_count, l_bit_count;

  int checks = 0;
  int errors = 0;

  // Reference model: bits collected so far, and the held word for each order.
  logic         bits_q[$];
  bit           holding = 1'b0;
  logic [W-1:0] exp_m = '0;
  logic [W-1:0] exp_l = '0;
  bit           started = 1'b0;

  // Clock generation.
  always #5 clk = ~clk;

  serial_word_collector #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(m_bit_ready), .flush(flush), .word_out(m_word_out),
    .word_valid(m_word_valid), .word_ready(word_ready), .bit_count(m_bit_count)
  );

  serial_word_collector #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(l_bit_ready), .flush(flush), .word_out(l_word_out),
    .word_valid(l_word_valid), .word_ready(word_ready), .bit_count(l_bit_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word value from the first W collected bits: arithmetic weighting by position.
  task automatic model_complete();
    logic [W-1:0] wm, wl;
    wm = '0;
    wl = '0;
    for (int i = 0; i < W; i++) begin
      if (bits_q[i]) begin
        wm = wm + (W'(1) << (W-1-i));
        wl = wl + (W'(1) << i);
      end
    end
    exp_m = wm;
    exp_l = wl;
    holding = 1'b1;
    bits_q.delete();
  endtask

  // One clock cycle: apply inputs, check ready, advance model, check outputs.
  task automatic step(input logic v, input logic b, input logic f,
                      input logic wr, input logic r);
    bit_valid  = v;
    bit_in     = b;
    flush      = f;
    word_ready = wr;
    rst        = r;
    #1;
    if (started) begin
      chk("m_ready_pre", m_bit_ready, !holding);
      chk("l_ready_pre", l_bit_ready, !holding);
    end
    @(posedge clk);
    if (r) begin
      bits_q.delete();
      holding = 1'b0;
      exp_m   = '0;
      exp_l   = '0;
      started = 1'b1;
    end else if (holding) begin
      if (wr) holding = 1'b0;
    end else if (f) begin
      bits_q.delete();
    end else if (v) begin
      bits_q.push_back(b);
      if (bits_q.size() == W) model_complete();
    end
    #1;
    chk("m_valid", m_word_valid, holding);
    chk("l_valid", l_word_valid, holding);
    chk("m_ready", m_bit_ready, !holding);
    chk("m_count", m_bit_count, bits_q.size());
    chk("l_count", l_bit_count, bits_q.size());
    chk("m_word", m_word_out, exp_m);
    chk("l_word", l_word_out, exp_l);
  endtask

  // Send 8 bits of val, val[7] first, with the given word_ready level.
  task automatic send_byte(input logic [7:0] val, input logic wr);
    for (int i = 7; i >= 0; i--) step(1'b1, val[i], 1'b0, wr, 1'b0);
  endtask

  initial begin
    // Reset and reset-state values.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_ready", m_bit_ready, 1'b1);
    chk("rst_word", m_word_out, 0);

    // Bits 1,0,1,1,0,0,1,0 back to back, word_ready high.
    send_byte(8'hB2, 1'b1);
    chk("b2_msb", m_word_out, 8'hB2);
    chk("4d_lsb", l_word_out, 8'h4D);
    chk("b2_valid", m_word_valid, 1'b1);
    chk("b2_ready_low", m_bit_ready, 1'b0);
    // One HOLD cycle, then the very next word is accepted immediately.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("b2_ready_back", m_bit_ready, 1'b1);
    send_byte(8'h3C, 1'b1);
    chk("3c_msb", m_word_out, 8'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 0xFF held for 5 cycles under backpressure with bit_valid asserted.
    send_byte(8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ff_hold", m_word_out, 8'hFF);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ff_released", m_word_valid, 1'b0);
    send_byte(8'h96, 1'b0);
    chk("96_fresh", m_word_out, 8'h96);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush after 3 bits, discarding the bit presented with it.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_cnt", m_bit_count, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("flush_cnt", m_bit_count, 0);
    send_byte(8'h55, 1'b0);
    chk("55_msb", m_word_out, 8'h55);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush during HOLD has no effect.
    send_byte(8'hA5, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("a5_kept", m_word_out, 8'hA5);
    chk("a5_valid", m_word_valid, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-word, then mid-HOLD.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_cnt", m_bit_count, 0);
    send_byte(8'hC3, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_hold_valid", m_word_valid, 1'b0);
    chk("rst_hold_word", m_word_out, 0);
    chk("rst_hold_ready", m_bit_ready, 1'b1);
    send_byte(8'h6E, 1'b0);
    chk("6e_after_rst", m_word_out, 8'h6E);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream consumer of the 2:1 mux output bit (Y) in the datapath.
- Samples one mux output bit per accepted cycle and packs WIDTH bits into a parallel word.
- Presents the word on a valid/ready output handshake and applies backpressure upstream with bit_ready.
- Sits between the mux select/data sequencing and the register/ALU stage that consumes whole words.

Parameters:
- WIDTH, 8, word length in bits; legal range >= 2.
- MSB_FIRST, 1, 1 = first accepted bit lands in word_out[WIDTH-1]; 0 = first accepted bit lands in word_out[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- bit_in  input  1  serial data bit, driven by the mux output Y.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  collector can accept a bit this cycle.
- flush  input  1  synchronous discard of a partially collected word.
- word_out  output  WIDTH  assembled word.
- word_valid  output  1  word_out holds a complete word.
- word_ready  input  1  downstream accepts word_out.
- bit_count  output  $clog2(WIDTH+1)  number of bits collected into the current word.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high. Reset takes priority over every other input.
- Reset values: state = COLLECT, shift register = 0, bit_count = 0, word_out = 0, word_valid = 0. bit_ready = 1 in the first cycle after reset.
- States: COLLECT and HOLD.
- bit_ready = (state == COLLECT). It is combinational from state only and never depends on bit_valid.
- Bit accept:
  - A bit is accepted when bit_valid && bit_ready && !flush.
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], bit_in}.
  - MSB_FIRST=0: shreg <= {bit_in, shreg[WIDTH-1:1]}.
  - bit_count increments by 1 on each accept.
- Completion:
  - The accept with bit_count == WIDTH-1 completes the word.
  - On the next edge, word_out <= the fully shifted value including this bit, word_valid <= 1, bit_count <= 0, state <= HOLD.
  - Latency: word_valid rises 1 cycle after the last bit is accepted.
- HOLD:
  - bit_ready = 0; bit_valid is ignored and no bits are lost upstream because ready was low.
  - word_out and word_valid stay stable until word_valid && word_ready.
  - On handshake: word_valid <= 0, state <= COLLECT, shreg <= 0.
  - Minimum period is WIDTH+1 cycles per word when word_ready is held high.
- After the handshake, word_out keeps the last word until the next completion; it is only meaningful while word_valid = 1.
- Flush:
  - In COLLECT: shreg <= 0 and bit_count <= 0. A bit presented in the same cycle is discarded.
  - In HOLD: no effect; the held word is not dropped.
- word_ready while in COLLECT: ignored.
- Reset mid-word or mid-HOLD: the partial or held word is lost and outputs return to reset values on the next edge.
- bit_count never reaches WIDTH. Its range is 0..WIDTH-1.

Test Plan:
- WIDTH=8, MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles, word_ready=1 -> word_valid high one cycle after the 8th bit with word_out=8'hB2; bit_ready low for exactly 1 cycle; next word accepted immediately after.
- MSB_FIRST=0, same bit sequence -> word_out=8'h4D.
- Complete 8'hFF, hold word_ready=0 for 5 cycles while driving bit_valid=1:
  - Expect word_valid=1 and word_out=8'hFF stable, and bit_ready=0 throughout.
  - Raise word_ready -> word_valid drops next cycle; the next 8 bits form a fresh word.
- Accept 3 bits (1,1,1), assert flush together with bit_valid and bit_in=1, then send 0,1,0,1,0,1,0,1 -> bit_count=0 after flush; word_out=8'h55.
- Assert flush while in HOLD with word 8'hA5 -> word_out stays 8'hA5 and word_valid stays 1 until word_ready.
- Assert rst after 5 accepted bits and again during HOLD -> next cycle bit_count=0, word_valid=0, word_out=0, bit_ready=1; the following full word assembles correctly.
